// File: rtl/fifo_send_sched.sv
// Shares one packet writer among NREQ requesters: round-robin arbitration, fs/fd handshake, fd watchdog and inter-packet gap.
// Define FIFO_SCHED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority.
module fifo_send_sched #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned GAP_CYC = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [4*NREQ-1:0]   req_cmd,
  output logic [NREQ-1:0]     ack,
  output logic                ack_err,
  output logic                busy,
  output logic [2:0]          grant_id,
  output logic                fs,
  input  logic                fd,
  output logic [3:0]          data_cmd,
  output logic                wr_err,
  output logic [2:0]          so_state
);

  localparam int unsigned CW       = $clog2(TIMEOUT);
  localparam int unsigned GW       = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int unsigned GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARB     = 3'd1,
    S_SEND    = 3'd2,
    S_RELEASE = 3'd3,
    S_ABORT   = 3'd4,
    S_GAP     = 3'd5
  } state_t;

  state_t          state, next_state;
  logic [CW-1:0]   wcnt;
  logic [GW-1:0]   gcnt;
  logic            found;
  logic [2:0]      win;
  logic [3:0]      win_cmd;
  logic [NREQ-1:0] grant_vec;
  logic            abort_fire;
  logic            done_fire;

  // Winner selection; the last hit in each loop is the highest-ranked requester.
  always_comb begin
    found   = 1'b0;
    win     = grant_id;
    win_cmd = 4'h0;
`ifdef FIFO_SCHED_PRIO_EN
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        win   = 3'(i);
      end
    end
`else
    begin
      int rr_idx;
      rr_idx = 0;
      for (int off = int'(NREQ); off >= 1; off--) begin
        rr_idx = int'(grant_id) + off;
        if (rr_idx >= int'(NREQ)) rr_idx = rr_idx - int'(NREQ);
        for (int j = 0; j < int'(NREQ); j++) begin
          if (j == rr_idx && req[j]) begin
            found = 1'b1;
            win   = 3'(j);
          end
        end
      end
    end
`endif
    for (int j = 0; j < int'(NREQ); j++) begin
      if (3'(j) == win) win_cmd = req_cmd[4*j +: 4];
    end
  end

  always_comb begin
    grant_vec = '0;
    for (int j = 0; j < int'(NREQ); j++) grant_vec[j] = (3'(j) == grant_id);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    abort_fire = 1'b0;
    done_fire  = 1'b0;
    case (state)
      S_IDLE:    if (|req) next_state = S_ARB;
      S_ARB:     next_state = found ? S_SEND : S_IDLE;
      S_SEND: begin
        // fd has precedence over the watchdog expiring in the same cycle
        if (fd) begin
          next_state = S_RELEASE;
        end else if (wcnt == CW'(TIMEOUT - 1)) begin
          next_state = S_ABORT;
          abort_fire = 1'b1;
        end
      end
      S_RELEASE: if (!fd) begin
        next_state = S_GAP;
        done_fire  = 1'b1;
      end
      S_ABORT:   next_state = S_GAP;
      S_GAP:     if (gcnt == GW'(GAP_LAST)) next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // Grant/command capture and the SEND/GAP cycle counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_id <= 3'(NREQ - 1);
      data_cmd <= 4'h0;
      wcnt     <= '0;
      gcnt     <= '0;
    end else begin
      if (state == S_ARB && found) begin
        grant_id <= win;
        data_cmd <= win_cmd;
      end
      wcnt <= (state == S_SEND) ? wcnt + CW'(1) : '0;
      gcnt <= (state == S_GAP)  ? gcnt + GW'(1) : '0;
    end
  end

  // Outputs registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fs      <= 1'b0;
      busy    <= 1'b0;
      wr_err  <= 1'b0;
      ack_err <= 1'b0;
      ack     <= '0;
    end else begin
      fs      <= (next_state == S_SEND);
      busy    <= (next_state != S_IDLE);
      wr_err  <= abort_fire;
      ack_err <= abort_fire;
      ack     <= (abort_fire || done_fire) ? grant_vec : '0;
    end
  end

  assign so_state = state;

endmodule

// File: tb/tb_fifo_send_sched.sv
// Scoreboard bench for fifo_send_sched with a behavioural packet-writer model driving fd.
// Expectations follow FIFO_SCHED_PRIO_EN when the macro is defined for the build.
module tb_fifo_send_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] req_cmd;
  logic [3:0]  ack;
  logic        ack_err;
  logic        busy;
  logic [2:0]  grant_id;
  logic        fs;
  logic        fd;
  logic [3:0]  data_cmd;
  logic        wr_err;
  logic [2:0]  so_state;

  fifo_send_sched #(.NREQ(4), .TIMEOUT(256), .GAP_CYC(2)) dut (
    .clk(clk), .rst(rst), .req(req), .req_cmd(req_cmd),
    .ack(ack), .ack_err(ack_err), .busy(busy), .grant_id(grant_id),
    .fs(fs), .fd(fd), .data_cmd(data_cmd), .wr_err(wr_err), .so_state(so_state)
  );

  typedef struct {
    logic [3:0] ack;
    logic       err;
    logic [3:0] cmd;
    int         fs_len;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   vectors     = 0;
  int   miscompares = 0;
  int   fd_delay    = 0;
  int   wcnt        = 0;
  int   fs_run      = 0;
  int   acks_seen   = 0;
  int   wr_err_cnt  = 0;
  int   snap;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [3:0] a, input logic er, input logic [3:0] c, input int len);
    exp_t x;
    x.ack = a; x.err = er; x.cmd = c; x.fs_len = len;
    sb.push_back(x);
  endtask

  task automatic wait_ack(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack == 4'b0 && n < budget);
    check("ack_seen", 32'(|ack), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Writer model: fd rises in the fd_delay-th cycle of fs, drops once fs is low.
  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      wcnt = 0;
      fd   = 1'b0;
    end else if (fs) begin
      wcnt++;
      if (fd_delay != 0 && wcnt == fd_delay) fd = 1'b1;
    end else begin
      wcnt = 0;
      fd   = 1'b0;
    end
  end

  // Scoreboard consumer: every ack pops one expectation.
  always @(negedge clk) begin
    if (!rst) begin
      fs_run = 0;
    end else begin
      if (wr_err) wr_err_cnt++;
      if (ack != 4'b0) begin
        acks_seen++;
        check("ack_onehot", 32'($countones(ack)), 32'd1);
        if (sb.size() == 0) begin
          check("unexpected_ack", 32'(ack), 32'd0);
        end else begin
          e = sb.pop_front();
          check("ack", 32'(ack), 32'(e.ack));
          check("ack_err", 32'(ack_err), 32'(e.err));
          check("wr_err", 32'(wr_err), 32'(e.err));
          check("data_cmd", 32'(data_cmd), 32'(e.cmd));
          check("fs_len", 32'(fs_run), 32'(e.fs_len));
          check("fs_at_ack", 32'(fs), 32'd0);
        end
        fs_run = 0;
      end else if (fs) begin
        fs_run++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; req = 4'b0; req_cmd = 16'h0; fd_delay = 0;
    repeat (2) @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_ack_err", 32'(ack_err), 32'd0);
    check("rst_fs", 32'(fs), 32'd0);
    check("rst_data_cmd", 32'(data_cmd), 32'd0);
    check("rst_wr_err", 32'(wr_err), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(so_state), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Single packet with fd after 15 fs cycles
    req_cmd = 16'h0002; fd_delay = 15;
    push(4'b0001, 1'b0, 4'h2, 15);
    req = 4'b0001;
    @(negedge clk);
    check("t1_arb_state", 32'(so_state), 32'd1);
    check("t1_arb_fs", 32'(fs), 32'd0);
    @(negedge clk);
    check("t1_send_state", 32'(so_state), 32'd2);
    check("t1_send_fs", 32'(fs), 32'd1);
    check("t1_send_cmd", 32'(data_cmd), 32'h2);
    check("t1_grant", 32'(grant_id), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    wait_ack(400);
    req = 4'b0;
    check("t1_gap_state", 32'(so_state), 32'd5);
    @(negedge clk);
    check("t1_gap_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("t1_idle_busy", 32'(busy), 32'd0);
    check("t1_idle_state", 32'(so_state), 32'd0);

    // All four requesting continuously
    do_reset();
    req_cmd = 16'h3210; fd_delay = 3;
`ifdef FIFO_SCHED_PRIO_EN
    repeat (5) push(4'b0001, 1'b0, 4'h0, 3);
`else
    push(4'b0001, 1'b0, 4'h0, 3);
    push(4'b0010, 1'b0, 4'h1, 3);
    push(4'b0100, 1'b0, 4'h2, 3);
    push(4'b1000, 1'b0, 4'h3, 3);
    push(4'b0001, 1'b0, 4'h0, 3);
`endif
    req = 4'b1111;
    repeat (5) wait_ack(100);
    req = 4'b0;
    repeat (3) @(negedge clk);

    // Writer never answers: watchdog abort
    req_cmd = 16'h0A00; fd_delay = 0;
    push(4'b0100, 1'b1, 4'hA, 256);
    req = 4'b0100;
    wait_ack(400);
    req = 4'b0;
    check("t3_fs_after_abort", 32'(fs), 32'd0);
    repeat (3) @(negedge clk);

    // fd arrives on the final watchdog cycle
    req_cmd = 16'h5000; fd_delay = 256;
    push(4'b1000, 1'b0, 4'h5, 256);
    req = 4'b1000;
    wait_ack(400);
    req = 4'b0;
    repeat (3) @(negedge clk);

    // Request withdrawn during ARB
    snap = acks_seen;
    req_cmd = 16'h0070;
    req = 4'b0010;
    @(negedge clk);
    check("t5_arb_state", 32'(so_state), 32'd1);
    req = 4'b0;
    @(negedge clk);
    check("t5_back_idle", 32'(so_state), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    check("t5_fs_never", 32'(fs_run), 32'd0);
    check("t5_no_ack", 32'(acks_seen), 32'(snap));

    // Reset in the middle of SEND
    fd_delay = 0;
    req = 4'b0010;
    for (int n = 0; n < 10 && !fs; n++) @(negedge clk);
    check("t6_fs_up", 32'(fs), 32'd1);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_rst_fs", 32'(fs), 32'd0);
    check("t6_rst_ack", 32'(ack), 32'd0);
    check("t6_rst_state", 32'(so_state), 32'd0);
    check("t6_rst_grant", 32'(grant_id), 32'd3);
    req = 4'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    req_cmd = 16'h9070; fd_delay = 4;
    push(4'b0010, 1'b0, 4'h7, 4);
    push(4'b1000, 1'b0, 4'h9, 4);
    req = 4'b1010;
    wait_ack(100);
    req = 4'b1000;
    wait_ack(100);
    req = 4'b0;
    repeat (4) @(negedge clk);

    check("sb_empty", 32'(sb.size()), 32'd0);
    check("wr_err_count", 32'(wr_err_cnt), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_send_sched.md
Name: fifo_send_sched

Overview:
- Scheduler that shares the single packet writer (fifo_write) among NREQ requesters.
- Each requester posts a 4-bit packet command.
- The block arbitrates round-robin, drives the writer's fs/data_cmd start handshake and waits for fd. It then releases fs and returns a per-requester ack.
- A watchdog aborts a send whose fd never arrives, and a configurable gap separates back-to-back packets on the FIFO side.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 256, max cycles in SEND waiting for fd before abort (>=16).
- GAP_CYC, 2, idle cycles after each completed or aborted send before the next arbitration (0 allowed).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low.
- req  input  NREQ  per-requester send request; level, held until own ack.
- req_cmd  input  4*NREQ  command of requester i at bits [4i+3:4i].
- ack  output  NREQ  one-cycle pulse to the served requester.
- ack_err  output  1  qualifies ack: 1 = aborted by timeout.
- busy  output  1  high in any state other than IDLE.
- grant_id  output  3  index of the current or last granted requester.
- fs  output  1  start to writer.
- fd  input  1  done from writer.
- data_cmd  output  4  packet select to writer.
- wr_err  output  1  one-cycle pulse on watchdog abort.
- so_state  output  3  current state code, for debug.

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE. ack=0, ack_err=0, fs=0, data_cmd=0, wr_err=0, grant_id=NREQ-1, busy=0.
  - Round-robin pointer set so requester 0 has first priority.
- States and codes:
  - IDLE=0, ARB=1, SEND=2, RELEASE=3, ABORT=4, GAP=5.
  - Any illegal code goes to IDLE next cycle.
- IDLE: if |req, go to ARB.
- ARB (1 cycle):
  - Pick the first asserted req scanning from grant_id+1 upward, modulo NREQ.
  - Register the winner in grant_id and latch its req_cmd into data_cmd.
  - If no req is asserted in this cycle (requester withdrew), return to IDLE with no ack.
- SEND:
  - fs=1. data_cmd is held stable.
  - The watchdog counter clears on entry and increments every cycle.
  - fd=1: go to RELEASE.
  - Counter reaches TIMEOUT-1 with fd=0: go to ABORT.
  - If fd=1 and the counter reaches TIMEOUT-1 in the same cycle, fd wins.
- RELEASE:
  - fs=0. Wait for fd=0.
  - When fd=0 is seen: ack[grant_id]=1 and ack_err=0 for exactly that cycle, then go to GAP.
  - No timeout applies in RELEASE.
- ABORT (1 cycle):
  - fs=0, wr_err=1, ack[grant_id]=1, ack_err=1. Then go to GAP.
- GAP:
  - Counts GAP_CYC cycles, then goes to IDLE.
  - If GAP_CYC=0, goes to IDLE immediately after one cycle.
- Output timing:
  - All outputs are registered or decoded from registered state.
  - fs rises 2 cycles after req is sampled in IDLE.
- data_cmd changes only in ARB.
- Requests:
  - req changes while SEND/RELEASE are active do not affect the transaction in flight.
  - A requester still holding req after its ack is eligible again, but ranks last in the next arbitration.
- ack is one-hot or zero, never multi-hot.
- Reset asserted mid-SEND drops fs asynchronously. No ack is issued.

Optional Feature:
- Macro FIFO_SCHED_PRIO_EN.
- Defined: fixed priority is used instead of round-robin; lowest index wins in ARB regardless of grant_id. grant_id still reports the winner.
- Undefined: round-robin as above.

Test Plan:
- NREQ=4. req=4'b0001, req_cmd[3:0]=4'h2, writer model asserts fd 15 cycles after fs and drops fd 1 cycle after fs falls -> fs high exactly 15 cycles, data_cmd=4'h2, then ack=4'b0001 with ack_err=0, then busy low after GAP_CYC=2 cycles.
- req=4'b1111 held with cmds 0,1,2,3 -> serve order 0,1,2,3,0 and data_cmd sequence 0,1,2,3,0. With FIFO_SCHED_PRIO_EN defined -> requester 0 served repeatedly.
- req=4'b0100, writer model never asserts fd, TIMEOUT=256 -> fs high 256 cycles, then wr_err pulse, ack=4'b0100 with ack_err=1, fs=0.
- fd asserted in the same cycle the counter reaches TIMEOUT-1 -> normal RELEASE, ack_err=0, no wr_err.
- req=4'b0010 withdrawn in the ARB cycle -> return to IDLE, fs never rises, no ack.
- rst driven low 5 cycles into SEND -> fs=0, ack=0 and so_state=0 immediately. After release, a new req is served starting from requester 0.
